// File: rtl/segment_decoder.sv
// Receive side of the 16-segment display link: recovers the digit behind a segment
// pattern by sequentially searching the encoder's own table through a display instance.

module display (
    input  logic [3:0]  digit,
    output logic [15:0] segment
);

    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        segment = 16'h00B4;
        case (digit)
            4'd0: segment = 16'hFC30;
            4'd1: segment = 16'h6020;
            4'd2: segment = 16'hDDC0;
            4'd3: segment = 16'hF3C0;
            4'd4: segment = 16'h23C0;
            4'd5: segment = 16'hBBC0;
            4'd6: segment = 16'hBFC0;
            4'd7: segment = 16'hE000;
            4'd8: segment = 16'hFF00;
            4'd9: segment = 16'hFBC0;
            default: segment = 16'h00B4;
        endcase
    end

endmodule

module segment_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      seg_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       digit_out,
    output logic [1:0]       status,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] miss_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [1:0] ST_DIGIT   = 2'b00;
    localparam logic [1:0] ST_ERROR   = 2'b01;
    localparam logic [1:0] ST_UNKNOWN = 2'b10;

    localparam logic [3:0] LAST_DIGIT = 4'd9;
    localparam logic [3:0] ERROR_CAND = 4'd10;

    logic [1:0]  state;
    logic [15:0] capture;
    logic [3:0]  candidate;
    logic [15:0] cand_seg;
    logic        match;

    display u_display (
        .digit   (candidate),
        .segment (cand_seg)
    );

    assign match     = (cand_seg == capture);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state      <= IDLE;
            capture    <= '0;
            candidate  <= '0;
            digit_out  <= 4'hF;
            status     <= ST_DIGIT;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        capture   <= seg_in;
                        candidate <= '0;
                        state     <= SEARCH;
                    end
                end
                SEARCH: begin
                    // Ascending search: the lowest matching candidate wins on ambiguity.
                    if (match) begin
                        if (candidate <= LAST_DIGIT) begin
                            digit_out <= candidate;
                            status    <= ST_DIGIT;
                        end else begin
                            digit_out <= 4'hF;
                            status    <= ST_ERROR;
                        end
                        state <= DONE;
                    end else if (candidate == ERROR_CAND) begin
                        digit_out <= 4'hF;
                        status    <= ST_UNKNOWN;
                        state     <= DONE;
                    end else begin
                        candidate <= candidate + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                        if (status == ST_UNKNOWN && miss_count != {CNT_W{1'b1}})
                            miss_count <= miss_count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/segment_decoder.md
Name: segment_decoder

Overview:
- Receive side of the 16-segment display interface. Takes a 16-bit SEGMENT pattern and recovers the digit (0-9) that the `display` block would have encoded to produce it.
- Classifies the pattern as one of: a digit, the display error pattern, or unknown.
- Does not duplicate the code table. It instantiates one `display` and searches candidates sequentially, so the decoder cannot drift from the encoder.
- Sits between a captured/sniffed segment bus and self-check or readback logic. Uses valid/ready on both sides.

Parameters:
- CNT_W, 8, width of the saturating unknown-pattern counter MISS_COUNT.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-high reset.
- SEG_IN  input  16  segment pattern to decode, same bit order as `display` SEGMENT.
- IN_VALID  input  1  SEG_IN is valid.
- IN_READY  output  1  decoder can accept a pattern.
- DIGIT_OUT  output  4  decoded digit 0-9; 4'hF when STATUS != 2'b00.
- STATUS  output  2  2'b00 digit; 2'b01 display error pattern; 2'b10 unknown pattern.
- OUT_VALID  output  1  DIGIT_OUT/STATUS valid.
- OUT_READY  input  1  downstream accepts result.
- MISS_COUNT  output  CNT_W  number of STATUS=2'b10 results accepted downstream; saturates at all-ones.

Behaviour:
- Reset: the clock and reset are one clock, synchronous active-high. With RESET high at a rising edge:
  - state := IDLE, IN_READY = 1, OUT_VALID = 0;
  - DIGIT_OUT = 4'hF, STATUS = 2'b00, MISS_COUNT = 0, capture register = 0, candidate = 0.
  - RESET overrides every other input, in every state, including mid-SEARCH and while OUT_VALID is held.
- Internal: one `display` instance, DIGIT = candidate register (4 bits), output compared against the capture register.
- IDLE:
  - IN_READY = 1.
  - On an edge with IN_VALID = 1: capture SEG_IN, candidate := 0, go to SEARCH.
- SEARCH:
  - IN_READY = 0. Each cycle, compare display(candidate) with the captured pattern.
  - Match with candidate 0-9: DIGIT_OUT := candidate, STATUS := 00, go to DONE.
  - Match with candidate 10: this is the display error pattern. DIGIT_OUT := F, STATUS := 01, go to DONE.
  - No match and candidate = 10: DIGIT_OUT := F, STATUS := 10, go to DONE.
  - Otherwise: candidate := candidate + 1.
  - Candidates run 0..10 only; the candidate never wraps.
- DONE:
  - OUT_VALID = 1, IN_READY = 0. DIGIT_OUT and STATUS are held stable while OUT_READY = 0.
  - On an edge with OUT_READY = 1: go to IDLE.
  - If STATUS = 10 and MISS_COUNT != all-ones, MISS_COUNT += 1 on that same edge.
- Latency, measured from the accepting edge to the edge that raises OUT_VALID:
  - digit d: d+1 cycles;
  - error pattern: 11 cycles;
  - unknown pattern: 11 cycles.
- Throughput: one pattern per latency + 2 cycles minimum. DONE lasts at least 1 cycle and IDLE lasts 1 cycle; there is no bypass.
- Ordering and ignored inputs:
  - SEG_IN and IN_VALID are ignored outside IDLE.
  - OUT_READY is ignored outside DONE.
  - Priority is RESET > state logic.
- Ambiguous codes: if two digits ever share a pattern, the lowest candidate wins.
- Registered outputs: all outputs are registers, or decodes of the state register only.

Test Plan:
- Reset then idle: RESET high 2 cycles, then low → IN_READY = 1, OUT_VALID = 0, MISS_COUNT = 0, DIGIT_OUT = F.
- Digits, with OUT_READY tied to 1:
  - SEG_IN = 16'b1111110000110000 → DIGIT_OUT = 0, STATUS = 00, OUT_VALID 1 cycle after accept.
  - 16'b0110000000100000 → 1, latency 2.
  - 16'b1111111100000000 → 8, latency 9.
  - Sweep DIGIT 0-9 through a bench-side `display` into SEG_IN; each digit decodes to itself.
- Error pattern: SEG_IN = 16'b0000000010110100 → STATUS = 01, DIGIT_OUT = F, latency 11, MISS_COUNT unchanged.
- Unknown patterns:
  - SEG_IN = 16'h0000 then 16'hFFFF → STATUS = 10 each, latency 11, MISS_COUNT = 2.
  - With CNT_W = 2, five unknowns → MISS_COUNT saturates at 3.
- Backpressure: decode digit 8 with OUT_READY = 0 for 5 cycles.
  - OUT_VALID, DIGIT_OUT = 8 and STATUS = 00 stay stable; IN_READY = 0; a new SEG_IN with IN_VALID = 1 is ignored.
  - After OUT_READY = 1, one IDLE cycle follows with IN_READY = 1.
- Reset mid-operation:
  - Assert RESET during SEARCH of 16'hFFFF (candidate 5) → next cycle IDLE, OUT_VALID = 0, MISS_COUNT = 0.
  - Assert RESET in DONE → the result is discarded.
